// File: rtl/vslc_pkg.sv
// Shared types and constants for the VSLC program prefetcher: sequencer states,
// header byte offsets and the default EEPROM address width.
package vslc_pkg;

    localparam int VSLC_ADDR_W  = 9;

    localparam int HDR_START_HI = 0;
    localparam int HDR_START_LO = 1;
    localparam int HDR_END_HI   = 2;
    localparam int HDR_END_LO   = 3;

    typedef enum logic [2:0] {
        HEADER  = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        RESTART = 3'd3,
        HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_sync_fifo.sv
// Synchronous FIFO with occupancy count; the head word is read straight from
// storage registers, so rd_data is registered and cleared by reset.
module tt_um_jimktrains_vslc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_jimktrains_vslc_prefetch.sv
// Program-byte prefetch and scan sequencer between the EEPROM reader and the executor.
// Define VSLC_PREFETCH_HDR_CHECK_EN to reject bad headers (hdr_err, HALT).
//
// state   | meaning
// HEADER  | capturing the 4 header bytes by address
// RUN     | pushing program bytes in [start_addr, end_addr]
// DRAIN   | reader held, waiting for the executor to empty the FIFO
// RESTART | one-cycle restart + scan_start pulse, reader reloads start_addr
// HALT    | header rejected; stays here until rst
module tt_um_jimktrains_vslc_prefetch
    import vslc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = VSLC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic [ADDR_W-1:0] byte_addr,
    output logic              instr_valid,
    output logic [7:0]        instr_data,
    input  logic              instr_ready,
    output logic              hold_n,
    output logic              restart,
    output logic [ADDR_W-1:0] start_addr,
    output logic              scan_start,
    output logic              overflow,
    output logic              hdr_err
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] end_cand;
    logic              overflow_q;
    logic              hold_n_q;
    logic              restart_q;
    logic              scan_start_q;
    logic              wait_start_q;
    logic              push_req;
    logic              push_ok;
    logic              pop_ok;
    logic              bounded;
    logic              in_range;
    logic              hdr_bad;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;

    tt_um_jimktrains_vslc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req),
        .pop     (instr_ready),
        .wr_data (byte_data),
        .rd_data (instr_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign hold_n      = hold_n_q;
    assign restart     = restart_q;
    assign scan_start  = scan_start_q;
    assign start_addr  = start_q;
    assign overflow    = overflow_q;

    // End address as it will be once the low byte in flight is captured.
    assign end_cand = {end_q[ADDR_W-1:8], byte_data};

`ifdef VSLC_PREFETCH_HDR_CHECK_EN
    logic hdr_err_q;
    assign hdr_bad = (end_cand == '0) || (end_cand < start_q);
    assign hdr_err = hdr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_err_q <= 1'b0;
        end else if (state == HEADER && state_next == HALT) begin
            hdr_err_q <= 1'b1;
        end
    end
`else
    assign hdr_bad = 1'b0;
    assign hdr_err = 1'b0;
`endif

    // An unusable end address turns the scan into an open-ended stream from start_addr.
    assign bounded  = (end_q != '0) && (end_q >= start_q);
    assign in_range = (byte_addr >= start_q) && (!bounded || byte_addr <= end_q);

    assign pop_ok  = instr_ready && !fifo_empty;
    assign push_ok = push_req && (!fifo_full || pop_ok);

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        case (state)
            HEADER: begin
                if (byte_valid && byte_addr == ADDR_W'(HDR_END_LO)) begin
                    state_next = hdr_bad ? HALT : RUN;
                end
            end
            RUN: begin
                if (byte_valid && in_range && (!wait_start_q || byte_addr == start_q)) begin
                    push_req = 1'b1;
                    if (bounded && byte_addr == end_q) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = RESTART;
                end
            end
            RESTART: state_next = RUN;
            HALT:    state_next = HALT;
            default: state_next = HEADER;
        endcase
    end

    always_comb begin
        count_next = fifo_count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = fifo_count + CNT_W'(1);
            2'b01:   count_next = fifo_count - CNT_W'(1);
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HEADER;
            start_q      <= '0;
            end_q        <= '0;
            overflow_q   <= 1'b0;
            hold_n_q     <= 1'b1;
            restart_q    <= 1'b0;
            scan_start_q <= 1'b0;
            wait_start_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == HEADER && byte_valid) begin
                if (byte_addr == ADDR_W'(HDR_START_HI)) begin
                    start_q[ADDR_W-1:8] <= byte_data[ADDR_W-9:0];
                end
                if (byte_addr == ADDR_W'(HDR_START_LO)) begin
                    start_q[7:0] <= byte_data;
                end
                if (byte_addr == ADDR_W'(HDR_END_HI)) begin
                    end_q[ADDR_W-1:8] <= byte_data[ADDR_W-9:0];
                end
                if (byte_addr == ADDR_W'(HDR_END_LO)) begin
                    end_q[7:0] <= byte_data;
                end
            end
            if (push_req && fifo_full && !pop_ok) begin
                overflow_q <= 1'b1;
            end
            // Reader may still deliver stale bytes after a reload; wait for start_addr.
            if (state == RESTART) begin
                wait_start_q <= 1'b1;
            end else if (push_req) begin
                wait_start_q <= 1'b0;
            end
            restart_q    <= (state_next == RESTART);
            scan_start_q <= (state_next == RESTART) || (state == HEADER && state_next == RUN);
            // Threshold at DEPTH-1 leaves room for the byte already in flight.
            hold_n_q     <= !((state_next == DRAIN) || (state_next == HALT) ||
                              (count_next >= CNT_W'(DEPTH - 1)));
        end
    end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_prefetch.sv
// Directed self-checking bench for tt_um_jimktrains_vslc_prefetch (DEPTH=8, ADDR_W=9).
module tb_tt_um_jimktrains_vslc_prefetch;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [ADDR_W-1:0] byte_addr;
    logic              instr_valid;
    logic [7:0]        instr_data;
    logic              instr_ready;
    logic              hold_n;
    logic              restart;
    logic [ADDR_W-1:0] start_addr;
    logic              scan_start;
    logic              overflow;
    logic              hdr_err;

    int total = 0;
    int bad   = 0;
    int restart_cnt = 0;
    int scan_cnt    = 0;
    int both_cnt    = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    tt_um_jimktrains_vslc_prefetch #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_addr   (byte_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .hold_n      (hold_n),
        .restart     (restart),
        .start_addr  (start_addr),
        .scan_start  (scan_start),
        .overflow    (overflow),
        .hdr_err     (hdr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (instr_valid && instr_ready) rx_q.push_back(instr_data);
        if (restart) restart_cnt++;
        if (scan_start) scan_cnt++;
        if (restart && scan_start) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        byte_valid = 1'b1;
        byte_addr  = a;
        byte_data  = d;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] h0, input logic [7:0] h1,
                               input logic [7:0] h2, input logic [7:0] h3);
        send(9'd0, h0);
        send(9'd1, h1);
        send(9'd2, h2);
        send(9'd3, h3);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        byte_valid  = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        restart_cnt = 0;
        scan_cnt    = 0;
        both_cnt    = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_restart(input int target);
        int n = 0;
        while (restart_cnt < target && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (restart_cnt < target) begin
            bad++;
            $display("FAIL restart_wait: restart pulses %0d, required %0d", restart_cnt, target);
        end
    endtask

    task automatic check_rx(input string name);
        total++;
        if (rx_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (rx_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s_byte%0d: got %h, required %h", name, i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; byte_valid = 1'b0; byte_addr = '0; byte_data = '0; instr_ready = 1'b0;
        tick();
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b, required 0", instr_valid); end
        total++; if (instr_data !== 8'h00) begin bad++; $display("FAIL rst_instr_data: got %h, required 00", instr_data); end
        total++; if (hold_n !== 1'b1) begin bad++; $display("FAIL rst_hold_n: got %b, required 1", hold_n); end
        total++; if (restart !== 1'b0 || scan_start !== 1'b0) begin bad++; $display("FAIL rst_pulses: got restart=%b scan_start=%b, required 0 0", restart, scan_start); end
        total++; if (start_addr !== 9'h000) begin bad++; $display("FAIL rst_start_addr: got %h, required 000", start_addr); end
        total++; if (overflow !== 1'b0 || hdr_err !== 1'b0) begin bad++; $display("FAIL rst_sticky: got overflow=%b hdr_err=%b, required 0 0", overflow, hdr_err); end
        rst = 1'b0;
    endtask

    task automatic test_basic_scan();
        do_reset();
        instr_ready = 1'b1;
        send_header(8'h00, 8'h04, 8'h00, 8'h07);
        total++; if (scan_start !== 1'b1) begin bad++; $display("FAIL hdr_scan_start: got %b, required 1", scan_start); end
        total++; if (start_addr !== 9'h004) begin bad++; $display("FAIL basic_start_addr: got %h, required 004", start_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid: got %b, required 0", instr_valid); end
        send(9'd4, 8'hA1);
        total++; if (instr_valid !== 1'b1 || instr_data !== 8'hA1) begin bad++; $display("FAIL push_latency: got valid=%b data=%h, required 1 a1", instr_valid, instr_data); end
        send(9'd5, 8'hA2);
        send(9'd6, 8'hA3);
        send(9'd7, 8'hA4);
        total++; if (hold_n !== 1'b0) begin bad++; $display("FAIL drain_hold_n: got %b, required 0", hold_n); end
        wait_restart(1);
        tick();
        tick();
        total++; if (restart_cnt !== 1 || both_cnt !== 1 || scan_cnt !== 2) begin bad++; $display("FAIL restart_pulse: got restart=%0d both=%0d scan=%0d, required 1 1 2", restart_cnt, both_cnt, scan_cnt); end
        total++; if (hold_n !== 1'b1) begin bad++; $display("FAIL run_hold_n: got %b, required 1", hold_n); end
        // second scan: an address below start must be discarded
        send(9'd3, 8'hEE);
        send(9'd4, 8'hB1);
        send(9'd5, 8'hB2);
        send(9'd6, 8'hB3);
        send(9'd7, 8'hB4);
        wait_restart(2);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        check_rx("basic");
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_header(8'h00, 8'h04, 8'h00, 8'h0F);
        for (int i = 0; i < DEPTH - 1; i++) begin
            send(9'(4 + i), 8'(8'h10 + i));
            if (i == DEPTH - 3) begin
                total++; if (hold_n !== 1'b1) begin bad++; $display("FAIL bp_below_thresh: got hold_n=%b, required 1", hold_n); end
            end
        end
        total++; if (hold_n !== 1'b0) begin bad++; $display("FAIL bp_at_thresh: got hold_n=%b, required 0", hold_n); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b, required 0", overflow); end
        total++; if (instr_valid !== 1'b1 || instr_data !== 8'h10) begin bad++; $display("FAIL bp_head_stable: got valid=%b data=%h, required 1 10", instr_valid, instr_data); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (hold_n !== 1'b1) begin bad++; $display("FAIL bp_release: got hold_n=%b, required 1", hold_n); end
        total++; if (instr_data !== 8'h11) begin bad++; $display("FAIL bp_head_advance: got %h, required 11", instr_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_header(8'h00, 8'h04, 8'h00, 8'h1F);
        for (int i = 0; i < DEPTH; i++) send(9'(4 + i), 8'(8'hC0 + i));
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_at_full: got %b, required 0", overflow); end
        send(9'(4 + DEPTH), 8'hC8);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        rx_q.delete();
        instr_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) tick();
        instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'hC0 + i));
        check_rx("ovf");
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        send_header(8'h00, 8'h04, 8'h00, 8'h1F);
        for (int i = 0; i < DEPTH; i++) send(9'(4 + i), 8'(8'hD0 + i));
        rx_q.delete();
        instr_ready = 1'b1;
        send(9'(4 + DEPTH), 8'hD8);
        instr_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow: got %b, required 0", overflow); end
        total++; if (instr_valid !== 1'b1 || instr_data !== 8'hD1 || hold_n !== 1'b0) begin bad++; $display("FAIL pp_state: got valid=%b data=%h hold_n=%b, required 1 d1 0", instr_valid, instr_data, hold_n); end
        instr_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) tick();
        instr_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) exp_q.push_back(8'(8'hD0 + i));
        check_rx("pp");
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        send_header(8'h00, 8'h04, 8'h00, 8'h06);
        send(9'd4, 8'hE0);
        send(9'd5, 8'hE1);
        send(9'd6, 8'hE2);
        total++; if (hold_n !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL drain3_state: got hold_n=%b valid=%b, required 0 1", hold_n, instr_valid); end
        rst = 1'b1;
        tick();
        total++; if (instr_valid !== 1'b0 || instr_data !== 8'h00 || hold_n !== 1'b1) begin bad++; $display("FAIL midrst_fifo: got valid=%b data=%h hold_n=%b, required 0 00 1", instr_valid, instr_data, hold_n); end
        total++; if (start_addr !== 9'h000 || overflow !== 1'b0 || restart !== 1'b0 || scan_start !== 1'b0) begin bad++; $display("FAIL midrst_regs: got start=%h ovf=%b rs=%b ss=%b, required 000 0 0 0", start_addr, overflow, restart, scan_start); end
        rst = 1'b0;
        restart_cnt = 0;
        rx_q.delete();
        instr_ready = 1'b1;
        send_header(8'h01, 8'h05, 8'h01, 8'h06);
        total++; if (start_addr !== 9'h105) begin bad++; $display("FAIL fresh_start_addr: got %h, required 105", start_addr); end
        send(9'h105, 8'hF1);
        send(9'h106, 8'hF2);
        wait_restart(1);
        exp_q = '{8'hF1, 8'hF2};
        check_rx("fresh");
    endtask

    task automatic test_bad_header();
        do_reset();
        send_header(8'h00, 8'h08, 8'h00, 8'h04);
`ifdef VSLC_PREFETCH_HDR_CHECK_EN
        total++; if (hdr_err !== 1'b1 || hold_n !== 1'b0) begin bad++; $display("FAIL hdr_reject: got hdr_err=%b hold_n=%b, required 1 0", hdr_err, hold_n); end
        send(9'd8, 8'h55);
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_no_push: got valid=%b, required 0", instr_valid); end
`else
        total++; if (hdr_err !== 1'b0 || hold_n !== 1'b1) begin bad++; $display("FAIL hdr_nocheck: got hdr_err=%b hold_n=%b, required 0 1", hdr_err, hold_n); end
        instr_ready = 1'b1;
        send(9'd8, 8'h55);
        send(9'd9, 8'h56);
        for (int i = 0; i < 10; i++) tick();
        total++; if (restart_cnt !== 0) begin bad++; $display("FAIL hdr_norestart: got %0d pulses, required 0", restart_cnt); end
        total++; if (start_addr !== 9'h008) begin bad++; $display("FAIL hdr_start_addr: got %h, required 008", start_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_in_drain();
        test_bad_header();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_jimktrains_vslc_prefetch.md
# tt_um_jimktrains_vslc_prefetch

Program-byte prefetch and scan sequencer between the SPI EEPROM byte reader and the instruction executor. Parses the 4-byte program header, buffers program bytes in a small FIFO with a valid/ready handshake to the executor, and backpressures the reader. On reaching the end address it drains, then restarts the reader at the start address and pulses a scan-start strobe used for the input snapshot.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 4.
- ADDR_W, 9: EEPROM byte address width.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- byte_valid  in  1  one-cycle strobe from the reader; byte_data/byte_addr are valid.
- byte_data  in  8  byte read.
- byte_addr  in  ADDR_W  address of byte_data.
- instr_valid  out  1  FIFO head valid.
- instr_data  out  8  FIFO head byte.
- instr_ready  in  1  executor consumes the head when instr_valid && instr_ready.
- hold_n  out  1  low means the reader must pause.
- restart  out  1  one-cycle pulse: the reader reloads at start_addr.
- start_addr  out  ADDR_W  program start address from the header.
- scan_start  out  1  one-cycle pulse at the start of each scan cycle.
- overflow  out  1  sticky; a push was attempted while full.
- hdr_err  out  1  sticky; header rejected.

## Operation
- Header layout: addr 0 bit0 = start_addr[8]; addr 1 = start_addr[7:0]; addr 2 bit0 = end_addr[8]; addr 3 = end_addr[7:0].
- States:
  - HEADER: capture header fields by byte_addr. After addr 3, check the header, then go to RUN.
  - RUN: push bytes with start_addr <= byte_addr <= end_addr; discard all others. A push of byte_addr == end_addr moves to DRAIN.
  - DRAIN: ignore byte_valid and hold hold_n low. When the FIFO is empty, go to RESTART.
  - RESTART: assert restart and scan_start for one cycle, then return to RUN.
  - HALT: terminal state, left only by rst; hold_n low, nothing pushed.
- Header check: the header is rejected if end_addr == 0 or end_addr < start_addr. Rejection sets hdr_err and enters HALT.
- scan_start also pulses once on the HEADER->RUN transition, so the first scan gets an input snapshot.
- hold_n is low in DRAIN and HALT, and whenever the FIFO occupancy is at least DEPTH-1. Otherwise it is high.
- Full FIFO:
  - A push while full is dropped and sets overflow.
  - A push and pop in the same cycle while full are both accepted.
- Empty FIFO: a push does not fall through in the same cycle.
- Occupancy counter is log2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.
- Reset values:
  - FIFO empty; state HEADER.
  - instr_valid 0, instr_data 0.
  - hold_n 1.
  - restart 0, scan_start 0.
  - start_addr 0, end_addr 0.
  - overflow 0, hdr_err 0.
- Reset mid-scan discards FIFO contents and the header. The reader is reset in parallel and re-reads from address 0.

## Timing
- Push latency: byte_valid in cycle N gives instr_valid in cycle N+1 if the FIFO was empty. instr_data is registered.
- Pop: the head advances the cycle after a valid&&ready handshake. instr_data is stable while instr_valid is high and instr_ready is low.
- hold_n is registered and updates the cycle after an occupancy change. The DEPTH-1 threshold absorbs one in-flight byte.
- DRAIN->RESTART occurs the cycle after the FIFO becomes empty. restart and scan_start are high in the same single cycle.
- The first byte accepted after RESTART must have byte_addr == start_addr. Lower addresses are discarded.

## Configuration
- VSLC_PREFETCH_HDR_CHECK_EN defined: header check as above; HALT and hdr_err are implemented.
- VSLC_PREFETCH_HDR_CHECK_EN undefined:
  - No range check, and hdr_err is tied 0.
  - end_addr == 0 stays in RUN, streams all bytes >= start_addr, and never restarts.
  - end_addr < start_addr also stays in RUN and never restarts.

## Structure
- Package vslc_pkg holds:
  - the state enum (HEADER, RUN, DRAIN, RESTART, HALT);
  - localparams for the header offsets HDR_START_HI=0, HDR_START_LO=1, HDR_END_HI=2, HDR_END_LO=3;
  - VSLC_ADDR_W=9.
- The FIFO is a sub-module, tt_um_jimktrains_vslc_sync_fifo (parameter DEPTH; push/pop/full/empty/count). It is reusable for a future output buffer.

## Test plan
- Header 00,04,00,07; bytes 4..7 = A1..A4; instr_ready=1 -> executor receives A1..A4 in order, then one restart+scan_start pulse, and start_addr=4.
- Same program with instr_ready=0 -> hold_n low after DEPTH-1 bytes, overflow stays 0. Raising instr_ready releases hold_n the cycle after the first pop.
- Force DEPTH+1 pushes while full with hold_n ignored -> extra byte dropped, overflow=1, FIFO contents intact.
- With the macro: header 00,08,00,04 -> hdr_err=1, state HALT, hold_n=0, no instr_valid. Without the macro: the same header gives no restart and hdr_err=0.
- Assert rst during DRAIN with 3 entries -> next cycle instr_valid=0, hold_n=1, all reset values; a fresh header parses correctly.
- Full FIFO with simultaneous push and pop -> both accepted, occupancy unchanged, overflow=0.
